// File: rtl/in_video_mux_ctrl.sv
// Frame-synchronous select controller for the 30-bit input-video mux.
// Debounces the panel-test pad pins, arbitrates manual requests against an
// automatic pattern cycler, and applies every select change on a vsync pulse
// so the panel never shows a torn frame.
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   vsync_p           one-clock frame-start pulse (clk domain)
//   pad_white_in      async pad pin, white/red request (active high)
//   pad_black_in      async pad pin, black request (active high)
//   red_sel           register bit: white request shows red (mux backup)
//   test_req          register bit: show the test pattern
//   auto_run          register bit: enable the auto cycle
//   test_on, pad_white, pad_black, backup   registered mux selects
//   state             current state code (status readback)
//   step_cnt          frames elapsed in the current auto step
module in_video_mux_ctrl #(
    parameter int unsigned DEB_CYC     = 16,
    parameter int unsigned STEP_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync_p,
    input  logic       pad_white_in,
    input  logic       pad_black_in,
    input  logic       red_sel,
    input  logic       test_req,
    input  logic       auto_run,
    output logic       test_on,
    output logic       pad_white,
    output logic       pad_black,
    output logic       backup,
    output logic [2:0] state,
    output logic [7:0] step_cnt
);

    localparam int unsigned CW = 16;  // debounce counter width
    localparam int unsigned SW = 8;   // step counter width
    localparam int unsigned NP = 2;   // pads: [0] white, [1] black

    typedef enum logic [2:0] {
        S_NORM  = 3'd0,
        S_TEST  = 3'd1,
        S_WHITE = 3'd2,
        S_RED   = 3'd3,
        S_BLACK = 3'd4
    } state_t;

    // Next step of the auto sequence TEST -> WHITE -> RED -> BLACK -> TEST.
    function automatic state_t auto_next(input state_t s);
        case (s)
            S_TEST:  auto_next = S_WHITE;
            S_WHITE: auto_next = S_RED;
            S_RED:   auto_next = S_BLACK;
            default: auto_next = S_TEST;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Pad synchronisers and debouncers
    // ------------------------------------------------------------------
    logic [NP-1:0]         pad_in;
    logic [NP-1:0]         sync1_q;
    logic [NP-1:0]         sync2_q;
    logic [NP-1:0]         deb_q;
    logic [NP-1:0]         deb_d;
    logic [NP-1:0][CW-1:0] deb_cnt_q;
    logic [NP-1:0][CW-1:0] deb_cnt_d;

    assign pad_in = {pad_black_in, pad_white_in};

    // Two-flop synchroniser per pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pad_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: level must differ for DEB_CYC consecutive clocks to flip.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < int'(NP); i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == CW'(DEB_CYC - 1)) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= '0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Target selection. Uses deb_d so a debounce completing on the vsync
    // clock is already honoured on that frame boundary.
    // ------------------------------------------------------------------
    state_t tgt_state;
    logic   tgt_auto;

    always_comb begin
        tgt_state = S_NORM;
        tgt_auto  = 1'b0;
        if (deb_d[1]) begin
            tgt_state = S_BLACK;
        end else if (deb_d[0]) begin
            tgt_state = red_sel ? S_RED : S_WHITE;
        end else if (test_req) begin
            tgt_state = S_TEST;
        end else if (auto_run) begin
            tgt_auto = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] step_q;
    logic [SW-1:0] step_d;
    logic          auto_q;   // last applied target came from the auto cycler
    logic          auto_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NORM;
            step_q  <= '0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            auto_q  <= auto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        auto_d  = auto_q;
        case (state_q)
            S_NORM, S_TEST, S_WHITE, S_RED, S_BLACK: begin
                if (vsync_p) begin
                    if (!tgt_auto) begin
                        state_d = tgt_state;
                        step_d  = '0;
                        auto_d  = 1'b0;
                    end else if (!auto_q) begin
                        // Fresh entry into auto always restarts at TEST.
                        state_d = S_TEST;
                        step_d  = '0;
                        auto_d  = 1'b1;
                    end else if (step_q == SW'(STEP_FRAMES - 1)) begin
                        state_d = auto_next(state_q);
                        step_d  = '0;
                    end else begin
                        step_d  = step_q + SW'(1);
                    end
                end
            end
            default: begin
                // Illegal code: recover without waiting for a frame boundary.
                state_d = S_NORM;
                step_d  = '0;
                auto_d  = 1'b0;
            end
        endcase
    end

    // Registered select decode, taken from the next state so the mux sees
    // the change on the same edge the state register updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            test_on   <= 1'b0;
            pad_white <= 1'b0;
            pad_black <= 1'b0;
            backup    <= 1'b0;
        end else begin
            test_on   <= (state_d == S_TEST);
            pad_white <= (state_d == S_WHITE) || (state_d == S_RED);
            pad_black <= (state_d == S_BLACK);
            backup    <= (state_d == S_RED);
        end
    end

    assign state    = state_q;
    assign step_cnt = step_q;

endmodule

// File: tb/tb_in_video_mux_ctrl.sv
// Bench for in_video_mux_ctrl: directed scenarios plus random pad/register/vsync
// traffic, checked every clock against a frame-level reference model.
module tb_in_video_mux_ctrl;

    localparam int unsigned DEB   = 16;
    localparam int unsigned STEPF = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync_p = 1'b0;
    logic       pad_white_in = 1'b0;
    logic       pad_black_in = 1'b0;
    logic       red_sel = 1'b0;
    logic       test_req = 1'b0;
    logic       auto_run = 1'b0;
    logic       test_on;
    logic       pad_white;
    logic       pad_black;
    logic       backup;
    logic [2:0] state;
    logic [7:0] step_cnt;

    in_video_mux_ctrl #(.DEB_CYC(DEB), .STEP_FRAMES(STEPF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync_p      (vsync_p),
        .pad_white_in (pad_white_in),
        .pad_black_in (pad_black_in),
        .red_sel      (red_sel),
        .test_req     (test_req),
        .auto_run     (auto_run),
        .test_on      (test_on),
        .pad_white    (pad_white),
        .pad_black    (pad_black),
        .backup       (backup),
        .state        (state),
        .step_cnt     (step_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: pin history window for debounce, frame-level rules
    // for target selection and the auto cycle.
    // ------------------------------------------------------------------
    bit   wq[$];
    bit   bq[$];
    bit   m_deb_w, m_deb_b, m_auto;
    int   m_state, m_step, m_seq;
    int   seq_code[4] = '{1, 2, 3, 4};
    logic [14:0] exp_q[$];

    // True when the DEB pin samples that reached the synchroniser output all equal v.
    function automatic bit window_is(input bit q[$], input bit v);
        for (int i = 1; i <= int'(DEB); i++)
            if (q[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [14:0] expect_of(input int st, input int stp);
        logic [3:0] sel;
        case (st)
            1: sel = 4'b1000;
            2: sel = 4'b0100;
            3: sel = 4'b0101;
            4: sel = 4'b0010;
            default: sel = 4'b0000;
        endcase
        return {3'(st), 8'(stp), sel};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_deb_w = 0; m_deb_b = 0; m_auto = 0;
            m_state = 0; m_step = 0; m_seq = 0;
            wq.delete(); bq.delete(); exp_q.delete();
            for (int i = 0; i < int'(DEB) + 2; i++) begin
                wq.push_back(1'b0);
                bq.push_back(1'b0);
            end
        end else begin
            int manual;
            bit is_auto;
            wq.push_back(pad_white_in);
            bq.push_back(pad_black_in);
            if (window_is(wq, !m_deb_w)) m_deb_w = !m_deb_w;
            if (window_is(bq, !m_deb_b)) m_deb_b = !m_deb_b;
            void'(wq.pop_front());
            void'(bq.pop_front());
            if (vsync_p) begin
                is_auto = 0;
                manual  = 0;
                if (m_deb_b)       manual = 4;
                else if (m_deb_w)  manual = red_sel ? 3 : 2;
                else if (test_req) manual = 1;
                else if (auto_run) is_auto = 1;
                if (!is_auto) begin
                    m_state = manual; m_step = 0; m_auto = 0;
                end else begin
                    if (!m_auto) begin
                        m_auto = 1; m_seq = 0; m_step = 0;
                    end else if (m_step == int'(STEPF) - 1) begin
                        m_seq = (m_seq + 1) % 4; m_step = 0;
                    end else begin
                        m_step++;
                    end
                    m_state = seq_code[m_seq];
                end
            end
            exp_q.push_back(expect_of(m_state, m_step));
        end
    end

    // Monitor: compare every expectation the model produced for this edge.
    always @(posedge clk) begin
        logic [14:0] e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_outputs", int'({state, step_cnt, test_on, pad_white, pad_black, backup}), int'(e));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        @(negedge clk) vsync_p = 1'b1;
        @(negedge clk) vsync_p = 1'b0;
    endtask

    int st_tab[13] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 1};

    initial begin
        // Reset and idle
        wait_clk(5);
        chk("reset_state", int'(state), 0);
        chk("reset_selects", int'({test_on, pad_white, pad_black, backup}), 0);
        chk("reset_step", int'(step_cnt), 0);
        rst_n = 1'b1;
        repeat (3) begin
            wait_clk(7);
            vsync_pulse();
        end
        chk("idle_state", int'(state), 0);

        // Debounce: short glitch ignored, long hold accepted
        pad_black_in = 1'b1; wait_clk(10); pad_black_in = 1'b0;
        wait_clk(30); vsync_pulse();
        chk("glitch_ignored", int'(state), 0);
        pad_black_in = 1'b1; wait_clk(40); vsync_pulse();
        chk("black_state", int'(state), 4);
        chk("black_sel", int'(pad_black), 1);
        pad_black_in = 1'b0; wait_clk(40); vsync_pulse();
        chk("black_release", int'(state), 0);

        // Priority
        test_req = 1'b1; red_sel = 1'b1; pad_white_in = 1'b1;
        wait_clk(40); vsync_pulse();
        chk("red_state", int'(state), 3);
        chk("red_sels", int'({test_on, pad_white, pad_black, backup}), 4'b0101);
        pad_black_in = 1'b1; wait_clk(40); vsync_pulse();
        chk("both_pads_state", int'(state), 4);
        chk("both_pads_sels", int'({test_on, pad_white, pad_black, backup}), 4'b0010);
        pad_white_in = 1'b0; pad_black_in = 1'b0; test_req = 1'b0; red_sel = 1'b0;
        wait_clk(40); vsync_pulse();
        chk("manual_release", int'(state), 0);

        // Auto cycle
        auto_run = 1'b1;
        for (int k = 0; k < 13; k++) begin
            wait_clk(5); vsync_pulse();
            chk("auto_state", int'(state), st_tab[k]);
            chk("auto_step", int'(step_cnt), k % 3);
        end

        // Override and resume
        repeat (4) begin wait_clk(3); vsync_pulse(); end
        chk("pre_override_state", int'(state), 2);
        chk("pre_override_step", int'(step_cnt), 1);
        test_req = 1'b1; wait_clk(3); vsync_pulse();
        chk("override_state", int'(state), 1);
        chk("override_step", int'(step_cnt), 0);
        test_req = 1'b0; wait_clk(3); vsync_pulse();
        chk("resume_state", int'(state), 1);
        chk("resume_step", int'(step_cnt), 0);

        // Reset mid-operation
        pad_black_in = 1'b1; wait_clk(40); vsync_pulse();
        chk("pre_reset_state", int'(state), 4);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async_reset_black", int'(pad_black), 0);
        chk("async_reset_state", int'(state), 0);
        wait_clk(3); rst_n = 1'b1;
        wait_clk(40); vsync_pulse();
        chk("post_reset_state", int'(state), 4);
        pad_black_in = 1'b0; auto_run = 1'b0;
        wait_clk(40);

        // Random traffic
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            vsync_p = ($urandom % 6 == 0);
            if ($urandom % 25 == 0) pad_white_in = !pad_white_in;
            if ($urandom % 30 == 0) pad_black_in = !pad_black_in;
            if ($urandom % 60 == 0) red_sel  = !red_sel;
            if ($urandom % 80 == 0) test_req = !test_req;
            if ($urandom % 40 == 0) auto_run = !auto_run;
        end
        vsync_p = 1'b0;
        wait_clk(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
